// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle RV32M multiply/divide sequencer for the EX stage.
//
// One operation is accepted per start pulse while ready=1. Multiplies use a
// radix-2 shift-add loop and divides use a restoring loop, one bit per cycle,
// followed by a sign fix-up cycle and a one-cycle valid pulse.
//
// Ports:
//   clk     clock
//   rst     synchronous, active-low reset
//   start   request, sampled only while ready=1
//   flush   abort the current operation (result discarded, r unchanged)
//   funct3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b    rs1 / rs2 operands, sampled only at accept
//   ready   high in IDLE only
//   busy    ~ready
//   valid   one-cycle pulse, r valid this cycle
//   r       result; holds its value until the next valid
//
// Build option:
//   MULDIV_FAST_MUL_EN  multiplies use a single-cycle 33x33 signed product in
//                       IDLE and skip the iterative loop (valid two cycles
//                       after start). Undefined: every multiply is iterative
//                       and no hardware multiplier is inferred.

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] r
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_REM    = 3'd6;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state;
  logic [2:0]          op;
  logic [2*XLEN-1:0]   acc;       // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     opnd;      // |a| for multiply, |b| for divide
  logic                neg_res;   // negate product / quotient in FIX
  logic                neg_rem;   // negate remainder in FIX (dividend sign)
  logic [CNT_W-1:0]    cnt;

  // Accept-time decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;

  // Iteration datapath
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     dhi;
  logic [XLEN+1:0]   ddiff;
  logic [2*XLEN-1:0] div_next;

  // Fix-up datapath
  logic [2*XLEN-1:0] pfull;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   quo_res;
  logic [XLEN-1:0]   rem_res;
  logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa;
  logic signed [XLEN:0]     fb;
  logic signed [2*XLEN-1:0] fp;
`endif

  assign busy = ~ready;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
               (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) && (a == SMIN) && (b == '1);
  end

  // Shift-add multiply step: conditionally add multiplicand into hi, then
  // shift the whole {carry, hi, lo} right by one.
  always_comb begin
    msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {msum, acc[XLEN-1:1]};
  end

  // Restoring divide step: shift left, trial-subtract divisor from the upper
  // XLEN+1 bits, shift in a quotient 1 when no borrow.
  always_comb begin
    dhi   = acc[2*XLEN-1:XLEN-1];
    ddiff = {1'b0, dhi} - {2'b00, opnd};
    if (!ddiff[XLEN+1])
      div_next = {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {dhi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    pfull   = neg_res ? -acc : acc;
    mul_res = (op == F_MUL) ? pfull[XLEN-1:0] : pfull[2*XLEN-1:XLEN];
    quo_res = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_res = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2])
      fix_res = mul_res;
    else if (op[1])
      fix_res = rem_res;
    else
      fix_res = quo_res;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fa = {a_neg, a};
    fb = {b_neg, b};
    fp = (2*XLEN)'(fa) * (2*XLEN)'(fb);
  end
`endif

  // Special cases and fast multiplies preload acc with a ready-made
  // {remainder, quotient} / product and clear the sign flags, so FIX
  // selects the answer through the ordinary path without negation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      op      <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      ready   <= 1'b1;
      valid   <= 1'b0;
      r       <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            op    <= funct3;
            ready <= 1'b0;
            if (div_zero) begin
              acc     <= {a, {XLEN{1'b1}}};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= S_FIX;
            end else if (div_ovf) begin
              acc     <= {{XLEN{1'b0}}, SMIN};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= S_FIX;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              acc     <= fp;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= S_FIX;
`endif
            end else begin
              opnd    <= is_div ? b_mag : a_mag;
              acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= CNT_W'(XLEN);
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= S_FIX;
        end
        S_FIX: begin
          r     <= fix_res;
          valid <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq. Cycle N is the cycle in which start is
// presented; latency is the cycle index (relative to N) where valid is seen.

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [31:0] r;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 34;
`endif
  localparam int LAT_DIV = 34;
  localparam int LAT_SPC = 2;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .valid  (valid),
    .r      (r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle, scramble operands afterwards, then wait
  // (bounded) for valid and check result, latency and the pulse width.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_r, input int exp_lat);
    int  n;
    bit  seen;
    funct3 = f;
    a      = av;
    b      = bv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    funct3 = 3'($urandom);
    a      = $urandom;
    b      = $urandom;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (valid) seen = 1'b1;
    end
    chk({tag, " lat"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, " r"}, r, exp_r);
    tick();
    chk({tag, " pulse"}, {30'd0, valid, ready}, 32'b01);
  endtask

  initial begin
    int pulses;

    rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    a      = '0;
    b      = '0;
    tick();
    tick();
    chk("reset", {28'd0, ready, busy, valid, 1'b0}, 32'b1000);
    chk("reset r", r, 32'd0);
    rst = 1'b1;
    tick();

    // Multiplies
    do_op("MUL",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
    do_op("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
    do_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
    do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_MUL);
    do_op("MULH2",  3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_MUL);

    // Divides
    do_op("DIV",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV);
    do_op("REM",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_DIV);
    do_op("DIVU",   3'd5, 32'd100,       32'd7, 32'd14,        LAT_DIV);
    do_op("REMU",   3'd7, 32'd100,       32'd7, 32'd2,         LAT_DIV);
    do_op("DIV+-",  3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_DIV);

    // Special cases
    do_op("DIVU/0", 3'd5, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, LAT_SPC);
    do_op("REMU/0", 3'd7, 32'h0000_1234, 32'd0, 32'h0000_1234, LAT_SPC);
    do_op("DIV/0",  3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SPC);
    do_op("REM/0",  3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPC);
    do_op("DIVovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC);
    do_op("REMovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPC);

    // Leave a known nonzero result in r before the abort tests
    do_op("DIVU2",  3'd5, 32'd100, 32'd7, 32'd14, LAT_DIV);

    // Flush at N+10 of a divide
    funct3 = 3'd4; a = 32'd50; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush ready", {30'd0, ready, busy}, 32'b10);
    chk("flush valid", 32'(valid), 32'd0);
    chk("flush r", r, 32'd14);
    pulses = 0;
    repeat (40) begin
      tick();
      if (valid) pulses++;
    end
    chk("flush nopulse", 32'(pulses), 32'd0);
    do_op("after flush", 3'd5, 32'd50, 32'd5, 32'd10, LAT_DIV);

    // flush together with start in IDLE drops the start
    funct3 = 3'd3; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush+start", 32'(ready), 32'd1);

    // start held while busy is ignored; operands changing mid-op are ignored
    funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    funct3 = 3'd0; a = 32'd3; b = 32'd5;
    repeat (20) tick();
    start = 1'b0;
    pulses = 0;
    repeat (50) begin
      tick();
      if (valid) begin
        pulses++;
        chk("busy-start r", r, 32'd14);
      end
    end
    chk("busy-start pulses", 32'(pulses), 32'd1);

    // Reset mid-op at N+5
    funct3 = 3'd4; a = 32'd77; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("midrst flags", {29'd0, ready, busy, valid}, 32'b100);
    chk("midrst r", r, 32'd0);
    rst = 1'b1;
    tick();
    do_op("after rst", 3'd6, 32'd77, 32'd3, 32'd2, LAT_DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
